// File: rtl/iddmm_pkg.sv
// Shared types and defaults for the word-serial Montgomery sequencer.
// Holds the controller state encoding and the datapath latency default.
// Imported by iddmm_ctrl.
package iddmm_pkg;

  // Input-to-write-back latency of the iddmm_cal pipeline in cycles.
  localparam int DP_LAT_DEF = 28;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/iddmm_ctrl.sv
// Sequencer for the iddmm_cal datapath: clears a[], issues N rows of N+1 beats, counts write-backs.
// Latency: RAM addresses are decoded from state; dp_* counters lag them by one register stage.
// Backpressure: none; a new row waits in DRAIN until all N write-backs of the previous row land.
module iddmm_ctrl
  import iddmm_pkg::*;
#(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N),
  parameter int DP_LAT = DP_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] x_rd_addr,
  output logic [ADDR_W-1:0] y_rd_addr,
  output logic [ADDR_W-1:0] p_rd_addr,
  output logic [ADDR_W:0]   a_rd_addr,
  output logic [ADDR_W-1:0] dp_i_cnt,
  output logic [ADDR_W:0]   dp_j_cnt,
  output logic              dp_xp_zero,
  input  logic              dp_wr_a_en,
  input  logic [ADDR_W:0]   dp_wr_a_addr,
  input  logic [K-1:0]      dp_wr_a_data,
  output logic              a_wr_en,
  output logic [ADDR_W:0]   a_wr_addr,
  output logic [K-1:0]      a_wr_data
);

  localparam int FLUSH_W = $clog2(DP_LAT + 3);
  localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(DP_LAT + 2);
  localparam logic [FLUSH_W-1:0] FLUSH_ONE  = FLUSH_W'(1);
  localparam logic [ADDR_W:0]    J_LAST     = (ADDR_W + 1)'(N);
  localparam logic [ADDR_W:0]    J_ONE      = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]    W_LAST     = (ADDR_W + 1)'(N - 1);
  localparam logic [ADDR_W-1:0]  I_LAST     = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0]  I_ONE      = ADDR_W'(1);

  state_t              state;
  logic [ADDR_W-1:0]   i_cnt;
  logic [ADDR_W:0]     j_cnt;
  logic [ADDR_W:0]     wcnt;
  logic [FLUSH_W-1:0]  flush;
  logic                issue;
  logic                last_beat;

  assign issue     = (state == ISSUE);
  assign last_beat = (j_cnt == J_LAST);

  // Address phase: x/p stop at word N-1, the extra j==N beat reads word 0 and is zeroed downstream.
  assign x_rd_addr = (issue && !last_beat) ? j_cnt[ADDR_W-1:0] : '0;
  assign p_rd_addr = (issue && !last_beat) ? j_cnt[ADDR_W-1:0] : '0;
  assign y_rd_addr = issue ? i_cnt : '0;
  assign a_rd_addr = issue ? j_cnt : '0;

  // Main FSM with i/j/write-back counters and the post-reset flush countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      i_cnt <= '0;
      j_cnt <= '0;
      wcnt  <= '0;
      flush <= FLUSH_INIT;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      if (flush != '0) flush <= flush - FLUSH_ONE;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && flush == '0) begin
            state <= CLEAR;
            i_cnt <= '0;
            j_cnt <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (last_beat) begin
            state <= ISSUE;
            j_cnt <= '0;
          end else begin
            j_cnt <= j_cnt + J_ONE;
          end
        end
        ISSUE: begin
          if (last_beat) begin
            state <= DRAIN;
            wcnt  <= '0;
          end else begin
            j_cnt <= j_cnt + J_ONE;
          end
        end
        DRAIN: begin
          if (dp_wr_a_en) begin
            if (wcnt == W_LAST) begin
              wcnt  <= '0;
              j_cnt <= '0;
              if (i_cnt == I_LAST) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                i_cnt <= i_cnt + I_ONE;
                state <= ISSUE;
              end
            end else begin
              wcnt <= wcnt + J_ONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Align counters and the zero flag with the 1-cycle RAM read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_i_cnt   <= '0;
      dp_j_cnt   <= '0;
      dp_xp_zero <= 1'b0;
    end else begin
      dp_i_cnt   <= y_rd_addr;
      dp_j_cnt   <= a_rd_addr;
      dp_xp_zero <= issue && last_beat;
    end
  end

  // a[] write port: zero fill while clearing, datapath write-backs only while a run is in flight.
  always_comb begin
    a_wr_en   = 1'b0;
    a_wr_addr = '0;
    a_wr_data = '0;
    case (state)
      CLEAR: begin
        a_wr_en   = 1'b1;
        a_wr_addr = j_cnt;
      end
      ISSUE, DRAIN: begin
        a_wr_en   = dp_wr_a_en;
        a_wr_addr = dp_wr_a_addr;
        a_wr_data = dp_wr_a_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_iddmm_ctrl.sv
// Self-checking bench for iddmm_ctrl with N=4, K=128, DP_LAT=28.
// Drives a manual write-back stub or an automatic fixed-latency datapath model.
// Expected values come from row/beat arithmetic and a per-row write-back data function.
module tb_iddmm_ctrl;

  localparam int K      = 128;
  localparam int N      = 4;
  localparam int AW     = 2;
  localparam int DP_LAT = 28;
  localparam int PERIOD = (N + 1) + DP_LAT + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done;
  logic [AW-1:0] x_rd_addr, y_rd_addr, p_rd_addr, dp_i_cnt;
  logic [AW:0]   a_rd_addr, dp_j_cnt, a_wr_addr;
  logic          dp_xp_zero, a_wr_en;
  logic [K-1:0]  a_wr_data;
  logic          dp_wr_a_en;
  logic [AW:0]   dp_wr_a_addr;
  logic [K-1:0]  dp_wr_a_data;

  logic          auto_mode = 1'b0;
  logic          man_en = 1'b0;
  logic [AW:0]   man_addr = '0;
  logic [K-1:0]  man_data = '0;
  logic          stub_en;
  logic [AW:0]   stub_addr;
  logic [K-1:0]  stub_data;

  assign dp_wr_a_en   = auto_mode ? stub_en   : man_en;
  assign dp_wr_a_addr = auto_mode ? stub_addr : man_addr;
  assign dp_wr_a_data = auto_mode ? stub_data : man_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [63:0] seed = 64'h0;
  logic [K-1:0] obs_a [N+1];

  iddmm_ctrl #(.K(K), .N(N), .ADDR_W(AW), .DP_LAT(DP_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .x_rd_addr(x_rd_addr), .y_rd_addr(y_rd_addr), .p_rd_addr(p_rd_addr),
    .a_rd_addr(a_rd_addr), .dp_i_cnt(dp_i_cnt), .dp_j_cnt(dp_j_cnt),
    .dp_xp_zero(dp_xp_zero), .dp_wr_a_en(dp_wr_a_en), .dp_wr_a_addr(dp_wr_a_addr),
    .dp_wr_a_data(dp_wr_a_data), .a_wr_en(a_wr_en), .a_wr_addr(a_wr_addr),
    .a_wr_data(a_wr_data)
  );

  always #5 clk = ~clk;

  // Write-back data the model datapath produces for row ii, beat jj.
  function automatic logic [K-1:0] f_data(int ii, int jj);
    return {seed, 32'(ii), 32'(jj)};
  endfunction

  // Model datapath: every beat with j>=1 returns one write of address j-1, DP_LAT cycles later.
  logic          pe [DP_LAT+1];
  logic [AW:0]   pa [DP_LAT+1];
  logic [K-1:0]  pd [DP_LAT+1];
  always @(negedge clk) begin
    for (int k = DP_LAT; k > 0; k--) begin
      pe[k] = pe[k-1];
      pa[k] = pa[k-1];
      pd[k] = pd[k-1];
    end
    pe[0] = (dp_j_cnt != 0);
    pa[0] = dp_j_cnt - 1'b1;
    pd[0] = f_data(int'(dp_i_cnt), int'(dp_j_cnt));
    stub_en   = pe[DP_LAT];
    stub_addr = pa[DP_LAT];
    stub_data = pd[DP_LAT];
  end

  // Record what actually lands in the a[] RAM.
  always @(negedge clk) begin
    #3;
    if (a_wr_en === 1'b1) obs_a[a_wr_addr] = a_wr_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic outs_zero();
    return ({busy, done, x_rd_addr, y_rd_addr, p_rd_addr, a_rd_addr, dp_i_cnt, dp_j_cnt,
             dp_xp_zero, a_wr_en, a_wr_addr, a_wr_data} === '0);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    man_en = 1'b0;
    repeat (3) @(posedge clk);
    tick();
    rst = 1'b0;
  endtask

  // Start lands on the first edge where the flush counter has reached zero.
  task automatic accept_start();
    repeat (DP_LAT + 2) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    auto_mode = 1'b0;
    do_reset();
    checks++;
    if (!outs_zero()) begin
      errors++;
      $display("FAIL reset_outputs: busy=%0b done=%0b a_wr_en=%0b dp_j=%0d required all zero",
               busy, done, a_wr_en, dp_j_cnt);
    end
  endtask

  task automatic test_flush();
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_cycle5_ignored: busy=%0b required 0", busy);
    end
    repeat (DP_LAT + 1 - 5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_flush_edge_ignored: busy=%0b required 0", busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_accepted: busy=%0b required 1", busy);
    end
  endtask

  task automatic test_clear();
    for (int k = 0; k <= N; k++) begin
      checks++;
      if (a_wr_en !== 1'b1 || a_wr_addr !== (AW+1)'(k) || a_wr_data !== '0) begin
        errors++;
        $display("FAIL clear_write %0d: en=%0b addr=%0d data=%0h required en=1 addr=%0d data=0",
                 k, a_wr_en, a_wr_addr, a_wr_data, k);
      end
      if (k == 2) begin
        man_en = 1'b1;
        man_addr = 3'd3;
        man_data = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
        #1;
        checks++;
        if (a_wr_data !== '0 || a_wr_addr !== 3'd2) begin
          errors++;
          $display("FAIL clear_ignores_dp_write: addr=%0d data=%0h required addr=2 data=0",
                   a_wr_addr, a_wr_data);
        end
      end
      tick();
      man_en = 1'b0;
    end
  endtask

  task automatic test_issue();
    for (int j = 0; j <= N; j++) begin
      automatic int xe = (j < N) ? j : 0;
      automatic int dje = (j == 0) ? 0 : j - 1;
      checks++;
      if (a_rd_addr !== (AW+1)'(j) || y_rd_addr !== '0 || x_rd_addr !== AW'(xe) ||
          p_rd_addr !== AW'(xe) || dp_j_cnt !== (AW+1)'(dje) || dp_xp_zero !== 1'b0) begin
        errors++;
        $display("FAIL issue_beat %0d: a=%0d y=%0d x=%0d p=%0d dpj=%0d xpz=%0b required a=%0d y=0 x=%0d p=%0d dpj=%0d xpz=0",
                 j, a_rd_addr, y_rd_addr, x_rd_addr, p_rd_addr, dp_j_cnt, dp_xp_zero, j, xe, xe, dje);
      end
      start = (j == 2);
      tick();
    end
    start = 1'b0;
    checks++;
    if (dp_j_cnt !== (AW+1)'(N) || dp_xp_zero !== 1'b1 || a_rd_addr !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL issue_last_aligned: dpj=%0d xpz=%0b a=%0d busy=%0b required dpj=%0d xpz=1 a=0 busy=1",
               dp_j_cnt, dp_xp_zero, a_rd_addr, busy, N);
    end
    tick();
  endtask

  task automatic test_drain();
    for (int w = 0; w < N; w++) begin
      automatic int gap = $urandom_range(0, 4);
      man_en = 1'b1;
      man_addr = (AW+1)'(w);
      man_data = {$urandom, $urandom, $urandom, $urandom};
      #1;
      checks++;
      if (a_wr_en !== 1'b1 || a_wr_addr !== man_addr || a_wr_data !== man_data) begin
        errors++;
        $display("FAIL drain_passthrough %0d: en=%0b addr=%0d data=%0h required en=1 addr=%0d data=%0h",
                 w, a_wr_en, a_wr_addr, a_wr_data, man_addr, man_data);
      end
      tick();
      man_en = 1'b0;
      if (w < N - 1) begin
        if (w == N - 2) gap = gap + 8;
        for (int g = 0; g < gap; g++) begin
          checks++;
          if (y_rd_addr !== '0 || a_rd_addr !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drain_holds after %0d writes: y=%0d a=%0d busy=%0b required y=0 a=0 busy=1",
                     w + 1, y_rd_addr, a_rd_addr, busy);
          end
          tick();
        end
      end
    end
    checks++;
    if (y_rd_addr !== AW'(1) || a_rd_addr !== '0) begin
      errors++;
      $display("FAIL row1_first_beat: y=%0d a=%0d required y=1 a=0", y_rd_addr, a_rd_addr);
    end
    tick();
    checks++;
    if (a_rd_addr !== 3'd1 || y_rd_addr !== AW'(1)) begin
      errors++;
      $display("FAIL row1_second_beat: y=%0d a=%0d required y=1 a=1", y_rd_addr, a_rd_addr);
    end
  endtask

  task automatic test_full_run();
    int xp_q[$];
    int done_cnt = 0;
    int done_cyc = -1;
    int budget = 0;
    seed = {$urandom, $urandom};
    auto_mode = 1'b1;
    do_reset();
    accept_start();
    while (budget < 400 && !(done_cnt > 0 && busy === 1'b0)) begin
      if (dp_xp_zero === 1'b1) xp_q.push_back(cyc);
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (dp_wr_a_en === 1'b1 && busy === 1'b1 && done !== 1'b1) begin
        checks++;
        if (a_wr_en !== 1'b1 || a_wr_addr !== dp_wr_a_addr || a_wr_data !== dp_wr_a_data) begin
          errors++;
          $display("FAIL run_writeback: en=%0b addr=%0d data=%0h required en=1 addr=%0d data=%0h",
                   a_wr_en, a_wr_addr, a_wr_data, dp_wr_a_addr, dp_wr_a_data);
        end
      end
      tick();
      budget++;
    end
    checks++;
    if (budget >= 400) begin
      errors++;
      $display("FAIL run_timeout: busy=%0b done_cnt=%0d required completion in 400 cycles", busy, done_cnt);
    end
    checks++;
    if (xp_q.size() != N) begin
      errors++;
      $display("FAIL row_count: rows=%0d required %0d", xp_q.size(), N);
    end
    for (int r = 1; r < xp_q.size(); r++) begin
      checks++;
      if (xp_q[r] - xp_q[r-1] != PERIOD) begin
        errors++;
        $display("FAIL row_period %0d: got %0d cycles required %0d", r, xp_q[r] - xp_q[r-1], PERIOD);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL done_once: pulses=%0d required 1", done_cnt);
    end
    if (xp_q.size() > 0) begin
      checks++;
      if (done_cyc != xp_q[xp_q.size()-1] + DP_LAT + 1) begin
        errors++;
        $display("FAIL done_timing: cycle=%0d required %0d", done_cyc, xp_q[xp_q.size()-1] + DP_LAT + 1);
      end
    end
    for (int k = 0; k <= N; k++) begin
      automatic logic [K-1:0] ex = (k < N) ? f_data(N - 1, k + 1) : '0;
      checks++;
      if (obs_a[k] !== ex) begin
        errors++;
        $display("FAIL a_final[%0d]: got %0h required %0h", k, obs_a[k], ex);
      end
    end
  endtask

  task automatic test_reset_mid();
    int budget = 0;
    int inflight = 0;
    auto_mode = 1'b1;
    do_reset();
    accept_start();
    while (budget < 400 && !(y_rd_addr === AW'(2) && a_rd_addr === 3'd3)) begin
      tick();
      budget++;
    end
    checks++;
    if (budget >= 400) begin
      errors++;
      $display("FAIL row2_reach_timeout: y=%0d a=%0d required y=2 a=3", y_rd_addr, a_rd_addr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (!outs_zero()) begin
      errors++;
      $display("FAIL midrun_reset_outputs: busy=%0b a_rd=%0d dp_j=%0d a_wr_en=%0b required all zero",
               busy, a_rd_addr, dp_j_cnt, a_wr_en);
    end
    for (int k = 1; k <= DP_LAT + 4; k++) begin
      start = (k == 5);
      tick();
      start = 1'b0;
      if (stub_en === 1'b1) inflight++;
      checks++;
      if (a_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL inflight_dropped cycle %0d: a_wr_en=%0b required 0", k, a_wr_en);
      end
      if (k == 5) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL flush_restart_start_ignored: busy=%0b required 0", busy);
        end
      end
    end
    checks++;
    if (inflight != 2) begin
      errors++;
      $display("FAIL inflight_count: stub writes after reset=%0d required 2", inflight);
    end
  endtask

  initial begin
    test_reset();
    test_flush();
    test_clear();
    test_issue();
    test_drain();
    test_full_run();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
